// File: rtl/interval_monitor_pkg.sv
// Shared definitions for the interval monitor: register map offsets, the ID
// word, the edge-mode encoding and the per-slot configuration record.
package interval_monitor_pkg;

  // Global register byte addresses (slot window index 0).
  localparam logic [7:0] REG_ID       = 8'h00;
  localparam logic [7:0] REG_CONTROL  = 8'h04;
  localparam logic [7:0] REG_STATUS   = 8'h08;
  localparam logic [7:0] REG_IRQ_MASK = 8'h0C;

  // Offsets inside a 0x20-byte slot window.
  localparam logic [4:0] SLOT_CFG   = 5'h00;
  localparam logic [4:0] SLOT_LOWER = 5'h04;
  localparam logic [4:0] SLOT_UPPER = 5'h08;
  localparam logic [4:0] SLOT_COUNT = 5'h0C;
  localparam logic [4:0] SLOT_FIRST = 5'h10;

  localparam logic [15:0] ID_MAGIC   = 16'h1A5C;
  localparam logic [7:0]  ID_VERSION = 8'h02;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;

  // Bounds are held at bus width; only the low DIFF_W bits are ever written.
  typedef struct packed {
    logic [4:0]  ch;
    edge_mode_e  edge_sel;
    logic        en;
    logic [31:0] lower;
    logic [31:0] upper;
  } slot_cfg_t;

  localparam slot_cfg_t SLOT_CFG_RST = '{
    ch:       5'd0,
    edge_sel: EDGE_BOTH,
    en:       1'b0,
    lower:    32'h0033_0000,
    upper:    32'h0034_0000
  };

  function automatic logic [31:0] id_word(input int num_slots);
    return {ID_MAGIC, 8'(num_slots), ID_VERSION};
  endfunction

endpackage

// File: rtl/interval_monitor_slot.sv
// One monitor slot: matches tags on a channel/edge, measures the interval
// between consecutive matches, checks it against [lower, upper] two cycles
// later and keeps a sticky flag, a saturating counter and a first-failure
// capture.
// Ports: clk/rst; cfg (slot configuration); global_en; clear (global wipe);
//        cfg_wr (this slot's config was written); tag stream inputs;
//        fail_flag, count, first_diff, cap_valid status outputs.
module interval_slot
  import interval_monitor_pkg::*;
#(
  parameter int TIME_W = 64,
  parameter int DIFF_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_cfg_t         cfg,
  input  logic              global_en,
  input  logic              clear,
  input  logic              cfg_wr,
  input  logic              valid_tag,
  input  logic [TIME_W-1:0] tagtime,
  input  logic [4:0]        channel,
  input  logic              rising_edge,
  output logic              fail_flag,
  output logic [CNT_W-1:0]  count,
  output logic [DIFF_W-1:0] first_diff,
  output logic              cap_valid
);

  localparam logic [DIFF_W-1:0] DIFF_MAX = '1;

  logic              armed_q, armed_d;
  logic [TIME_W-1:0] prev_q, prev_d;
  logic              chk_q, chk_d;
  logic [DIFF_W-1:0] diff_q, diff_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIFF_W-1:0] first_q, first_d;
  logic              cap_q, cap_d;

  logic              edge_ok, match, kill, violation;
  logic [TIME_W-1:0] diff_full;
  logic [DIFF_W-1:0] diff_sat;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this combinational (no latch).
  always_comb begin
    edge_ok = 1'b0;
    case (cfg.edge_sel)
      EDGE_RISE: edge_ok = rising_edge;
      EDGE_FALL: edge_ok = ~rising_edge;
      EDGE_BOTH: edge_ok = 1'b1;
      default:   edge_ok = 1'b0;
    endcase
    match = valid_tag & global_en & cfg.en & (channel == cfg.ch) & edge_ok;

    // Full-width subtraction, then saturate anything that does not fit.
    diff_full = tagtime - prev_q;
    diff_sat  = (diff_full > TIME_W'(DIFF_MAX)) ? DIFF_MAX : diff_full[DIFF_W-1:0];

    // A clear or a config write kills both the arm state and any check
    // already in flight (stage 1 being loaded and stage 2 being evaluated).
    kill = clear | cfg_wr;

    armed_d = armed_q;
    prev_d  = prev_q;
    diff_d  = diff_q;
    chk_d   = 1'b0;
    if (match) begin
      prev_d  = tagtime;
      armed_d = 1'b1;
      chk_d   = armed_q;   // first match after disarm only arms
      diff_d  = diff_sat;
    end
    if (kill) begin
      armed_d = 1'b0;
      chk_d   = 1'b0;
    end

    violation = chk_q & ~kill &
                ((diff_q < cfg.lower[DIFF_W-1:0]) | (diff_q > cfg.upper[DIFF_W-1:0]));

    fail_d  = fail_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    cap_d   = cap_q;
    if (violation) begin
      fail_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (!cap_q) begin
        first_d = diff_q;
        cap_d   = 1'b1;
      end
    end
    if (clear) begin
      fail_d  = 1'b0;
      cnt_d   = '0;
      first_d = '0;
      cap_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: all flops are plain registers (no RAM), so all are reset; the
  // datapath ones too, which keeps traces free of X.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      prev_q  <= '0;
      chk_q   <= 1'b0;
      diff_q  <= '0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      cap_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      prev_q  <= prev_d;
      chk_q   <= chk_d;
      diff_q  <= diff_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      cap_q   <= cap_d;
    end
  end

  assign fail_flag  = fail_q;
  assign count      = cnt_q;
  assign first_diff = first_q;
  assign cap_valid  = cap_q;

endmodule

// File: rtl/interval_monitor.sv
// Multi-slot tag-interval checker. Holds the Wishbone register file, the
// global enable / clear control and the interrupt OR; the per-slot work is
// done by interval_slot instances.
// Ports: clk/rst (sync, active-high); tag stream (valid_tag, tagtime,
//        channel, rising_edge); Wishbone slave (wb_*); fail_flags (sticky,
//        per slot); irq = |(fail_flags & irq_mask).
module interval_monitor
  import interval_monitor_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int TIME_W    = 64,
  parameter int DIFF_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_tag,
  input  logic [TIME_W-1:0]    tagtime,
  input  logic [4:0]           channel,
  input  logic                 rising_edge,
  input  logic [7:0]           wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [NUM_SLOTS-1:0] fail_flags,
  output logic                 irq
);

  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 global_en_q, global_en_d;
  logic [NUM_SLOTS-1:0] irq_mask_q, irq_mask_d;
  slot_cfg_t            cfg_q [NUM_SLOTS];
  slot_cfg_t            cfg_d [NUM_SLOTS];

  logic                 wb_req, wr_en, clear;
  logic [2:0]           slot_sel;
  logic [4:0]           slot_off;
  logic [NUM_SLOTS-1:0] cfg_wr;
  logic [31:0]          rd_data, first_ext;

  logic [CNT_W-1:0]     slot_count [NUM_SLOTS];
  logic [DIFF_W-1:0]    slot_first [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_cap;

  always_comb begin
    wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
    wr_en    = wb_req & wb_we_i;
    slot_sel = wb_adr_i[7:5];
    slot_off = wb_adr_i[4:0];

    global_en_d = global_en_q;
    irq_mask_d  = irq_mask_q;
    cfg_d       = cfg_q;
    cfg_wr      = '0;
    clear       = 1'b0;
    rd_data     = '0;
    first_ext   = '0;

    if (slot_sel == 3'd0) begin
      case (wb_adr_i)
        REG_ID:   rd_data = id_word(NUM_SLOTS);
        REG_CONTROL: begin
          rd_data = {30'd0, global_en_q, 1'b0};
          if (wr_en) begin
            clear       = wb_dat_i[0];   // pulse only; reads back as 0
            global_en_d = wb_dat_i[1];
          end
        end
        REG_STATUS: rd_data = 32'(fail_flags);
        REG_IRQ_MASK: begin
          rd_data = 32'(irq_mask_q);
          if (wr_en) irq_mask_d = wb_dat_i[NUM_SLOTS-1:0];
        end
        default: ;
      endcase
    end

    // Window 1..NUM_SLOTS maps to slot 0..NUM_SLOTS-1; higher windows decode
    // to nothing and so read 0 and ignore writes.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_sel == 3'(i + 1)) begin
        case (slot_off)
          SLOT_CFG: begin
            rd_data = {15'd0, cfg_q[i].en, 6'd0, cfg_q[i].edge_sel, 3'd0, cfg_q[i].ch};
            if (wr_en) begin
              cfg_d[i].ch       = wb_dat_i[4:0];
              cfg_d[i].edge_sel = edge_mode_e'(wb_dat_i[9:8]);
              cfg_d[i].en       = wb_dat_i[16];
              cfg_wr[i]         = 1'b1;
            end
          end
          SLOT_LOWER: begin
            rd_data = cfg_q[i].lower;
            if (wr_en) begin
              cfg_d[i].lower = 32'(wb_dat_i[DIFF_W-1:0]);
              cfg_wr[i]      = 1'b1;
            end
          end
          SLOT_UPPER: begin
            rd_data = cfg_q[i].upper;
            if (wr_en) begin
              cfg_d[i].upper = 32'(wb_dat_i[DIFF_W-1:0]);
              cfg_wr[i]      = 1'b1;
            end
          end
          SLOT_COUNT: rd_data = 32'(slot_count[i]);
          SLOT_FIRST: begin
            first_ext = 32'(slot_first[i]);
            rd_data   = {slot_cap[i], first_ext[30:0]};
          end
          default: ;
        endcase
      end
    end

    ack_d = wb_req;
    dat_d = (wb_req & ~wb_we_i) ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      global_en_q <= 1'b0;
      irq_mask_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) cfg_q[i] <= SLOT_CFG_RST;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      global_en_q <= global_en_d;
      irq_mask_q  <= irq_mask_d;
      cfg_q       <= cfg_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    interval_slot #(
      .TIME_W (TIME_W),
      .DIFF_W (DIFF_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .cfg         (cfg_q[g]),
      .global_en   (global_en_q),
      .clear       (clear),
      .cfg_wr      (cfg_wr[g]),
      .valid_tag   (valid_tag),
      .tagtime     (tagtime),
      .channel     (channel),
      .rising_edge (rising_edge),
      .fail_flag   (fail_flags[g]),
      .count       (slot_count[g]),
      .first_diff  (slot_first[g]),
      .cap_valid   (slot_cap[g])
    );
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq      = |(fail_flags & irq_mask_q);

endmodule
